mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_LIMIT, default 4, number of consecutive data grants after which a waiting fetch wins.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 i_req  in  1  instruction fetch request; held high until i_ready.
REQ-007 i_addr  in  ADDR_W  fetch address; stable while i_req is high.
REQ-008 i_rdata  out  DATA_W  fetch data; valid only when i_ready is high.
REQ-009 i_ready  out  1  one-cycle completion pulse for the fetch.
REQ-010 d_req  in  1  load/store request; held high until d_ready.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  ADDR_W  load/store address; stable while d_req is high.
REQ-013 d_wdata  in  DATA_W  store data.
REQ-014 d_be  in  DATA_W/8  store byte enables.
REQ-015 d_rdata  out  DATA_W  load data; valid only when d_ready is high.
REQ-016 d_ready  out  1  one-cycle completion pulse for the load/store.
REQ-017 mem_en  out  1  single-port memory access strobe.
REQ-018 mem_we  out  1  memory write enable.
REQ-019 mem_addr  out  ADDR_W  memory address.
REQ-020 mem_wdata  out  DATA_W  memory write data.
REQ-021 mem_be  out  DATA_W/8  memory byte enables.
REQ-022 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-023 FSM states: IDLE, I_WAIT, D_WAIT.
REQ-024 IDLE, no requests: mem_en=0, stay IDLE.
REQ-025 IDLE, request present: issue the winner combinationally that cycle (mem_en=1); next state I_WAIT or D_WAIT.
REQ-026 Arbitration: d_req wins over i_req, unless starve_cnt == STARVE_LIMIT and i_req is high, in which case the fetch wins.
REQ-027 Fetch issue: mem_we=0, mem_addr=i_addr, mem_be=all ones, mem_wdata=0.
REQ-028 Data issue: mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata; mem_be=d_be for stores, all ones for loads.
REQ-029 I_WAIT: i_ready=1, i_rdata=mem_rdata, mem_en=0; next state IDLE.
REQ-030 D_WAIT: d_ready=1, d_rdata=mem_rdata for loads, 0 for stores; mem_en=0; next state IDLE.
REQ-031 Latency: 2 cycles from issue to ready; maximum throughput is one access per 2 cycles.
REQ-032 starve_cnt (0..STARVE_LIMIT, saturating) increments on a data grant while i_req is high, and clears on any fetch grant.
REQ-033 starve_cnt holds when a data grant occurs with i_req low.
REQ-034 Simultaneous i_req and d_req: exactly one is granted per IDLE cycle; the loser waits without a ready pulse.
REQ-035 i_ready and d_ready are never high in the same cycle.
REQ-036 Granted-requester type is registered at issue; the ready pulse goes to that requester even if its req drops during the WAIT cycle.

Reset
REQ-037 reset high: state=IDLE, starve_cnt=0 on the next posedge.
REQ-038 During reset, all outputs are 0: i_ready, d_ready, mem_en, mem_we, rdata, addr, wdata, be.
REQ-039 Reset asserted in a WAIT state discards the pending access; no ready pulse is issued after reset.

Structure
REQ-040 Package mem_arb_pkg SHALL hold the state enum arb_state_t and default ADDR_W, DATA_W, STARVE_LIMIT constants.
REQ-041 One sub-module, mem_arb_starve_ctr, SHALL implement the saturating starvation counter (inc, clr, sat output).
REQ-042 The memory array is external; the arbiter holds no data storage.

Verification
REQ-043 Reset held 2 cycles, then no requests -> all outputs 0, mem_en never high.
REQ-044 Lone fetch at i_addr=0x10, mem returns 0x00A00093 -> mem_en in cycle N, i_ready=1 with i_rdata=0x00A00093 in cycle N+1.
REQ-045 i_req and d_req (load 0x100) raised together -> data issued first (d_ready at N+1), fetch issued at N+2 (i_ready at N+3).
REQ-046 Store d_addr=0x104, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1, mem_be=4'b0011, d_ready one cycle later, d_rdata=0.
REQ-047 d_req and i_req held continuously -> after 4 data grants the fetch is granted, starve_cnt clears, pattern repeats 4:1.
REQ-048 reset asserted during D_WAIT -> no d_ready pulse, state IDLE, next request is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default sizing for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants that bypassed a waiting fetch; sat forces the next grant to the fetch.
// Updates one cycle after inc/clr; clr takes priority over inc.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(LIMIT))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign sat = (cnt == W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between a fetch port and a load/store port; issue to ready is 2 cycles.
// Requesters hold req until their ready pulse; data has priority unless the fetch has starved STARVE_LIMIT grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state;
  logic       d_we_q;
  logic       starve_sat;
  logic       can_issue;
  logic       fetch_grant;
  logic       data_grant;

  // Reset gates the issue path too, so nothing reaches memory while reset is held.
  assign can_issue   = !reset && (state == IDLE);
  assign fetch_grant = can_issue && i_req && (!d_req || starve_sat);
  assign data_grant  = can_issue && d_req && !fetch_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      d_we_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_grant) begin
            state <= I_WAIT;
          end else if (data_grant) begin
            state  <= D_WAIT;
            d_we_q <= d_we;
          end
        end
        I_WAIT:  state <= IDLE;
        D_WAIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (data_grant && i_req),
    .clr   (fetch_grant),
    .sat   (starve_sat)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (fetch_grant) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
      mem_be   = '1;
    end else if (data_grant) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_we ? d_be : '1;
    end
  end

  // Ready follows the granted type latched at issue, not the live req lines.
  assign i_ready = !reset && (state == I_WAIT);
  assign d_ready = !reset && (state == D_WAIT);
  assign i_rdata = i_ready ? mem_rdata : '0;
  assign d_rdata = (d_ready && !d_we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a behavioural single-port memory behind it.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];
  bit          ready_log[$];
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  bit          mem_loaded;
  bit          si, sd;
  int          done, ni, nd;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_word(int idx);
    logic [31:0] w;
    case (idx)
      4:       w = 32'h00A00093;
      8:       w = 32'h11112222;
      64:      w = 32'hCAFEF00D;
      65:      w = 32'h12345678;
      default: w = {16'hA5A5, 8'h00, idx[7:0]};
    endcase
    return w;
  endfunction

  // Behavioural memory: synchronous read, byte-enabled write.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (i_ready || d_ready) chk("ready_excl", {63'b0, i_ready & d_ready}, 64'd0);
    if (i_ready) begin
      ready_log.push_back(1'b1);
      chk("i_q_nonempty", {63'b0, i_exp_q.size() != 0}, 64'd1);
      if (i_exp_q.size() != 0) chk("i_rdata", i_rdata, i_exp_q.pop_front());
    end
    if (d_ready) begin
      ready_log.push_back(1'b0);
      chk("d_q_nonempty", {63'b0, d_exp_q.size() != 0}, 64'd1);
      if (d_exp_q.size() != 0) chk("d_rdata", d_rdata, d_exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(int budget);
    int n;
    bit ri, rd;
    n = 0;
    while ((i_req || d_req) && n < budget) begin
      @(negedge clk);
      ri = i_ready;
      rd = d_ready;
      tick();
      if (ri) i_req = 1'b0;
      if (rd) d_req = 1'b0;
      n++;
    end
    chk("serve_done", {62'b0, i_req, d_req}, 64'd0);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    reset = 1'b1; i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h104; d_wdata = 32'hFFFFFFFF; d_be = 4'hF;

    // Reset held two cycles with requests pending: every output stays 0.
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("rst_ctl", {56'b0, i_ready, d_ready, mem_en, mem_we, mem_be}, 64'd0);
      chk("rst_addr", mem_addr, 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    end
    tick();
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_be = '0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ctl", {56'b0, i_ready, d_ready, mem_en, mem_we, mem_be}, 64'd0);
    end

    // Lone fetch.
    tick();
    i_addr = 32'h10; i_req = 1'b1; i_exp_q.push_back(ref_mem[4]);
    @(negedge clk);
    chk("f_issue", {58'b0, mem_en, mem_we, mem_be}, {58'b0, 1'b1, 1'b0, 4'hF});
    chk("f_addr", mem_addr, 64'h10);
    chk("f_wdata", mem_wdata, 64'd0);
    chk("f_no_ready", {62'b0, i_ready, d_ready}, 64'd0);
    @(negedge clk);
    chk("f_ready", {61'b0, i_ready, d_ready, mem_en}, 64'b100);
    chk("f_rdata", i_rdata, 64'h00A00093);
    tick();
    i_req = 1'b0;

    // Simultaneous fetch and load: data first, fetch two cycles later.
    tick();
    i_addr = 32'h20; i_req = 1'b1; i_exp_q.push_back(ref_mem[8]);
    d_addr = 32'h100; d_we = 1'b0; d_be = 4'h0; d_req = 1'b1; d_exp_q.push_back(ref_mem[64]);
    @(negedge clk);
    chk("s_n0_issue", {62'b0, mem_en, mem_we}, 64'b10);
    chk("s_n0_addr", mem_addr, 64'h100);
    chk("s_n0_load_be", mem_be, 64'hF);
    @(negedge clk);
    chk("s_n1_ready", {61'b0, i_ready, d_ready, mem_en}, 64'b010);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    chk("s_n2_issue", {62'b0, mem_en, mem_we}, 64'b10);
    chk("s_n2_addr", mem_addr, 64'h20);
    @(negedge clk);
    chk("s_n3_ready", {62'b0, i_ready, d_ready}, 64'b10);
    tick();
    i_req = 1'b0;

    // Partial store, then read back the merged word.
    tick();
    d_addr = 32'h104; d_we = 1'b1; d_wdata = 32'hDEADBEEF; d_be = 4'b0011; d_req = 1'b1;
    d_exp_q.push_back(32'h0);
    ref_mem[65] = (ref_mem[65] & 32'hFFFF0000) | (32'hDEADBEEF & 32'h0000FFFF);
    @(negedge clk);
    chk("st_issue", {58'b0, mem_en, mem_we, mem_be}, {58'b0, 1'b1, 1'b1, 4'b0011});
    chk("st_addr", mem_addr, 64'h104);
    chk("st_wdata", mem_wdata, 64'hDEADBEEF);
    @(negedge clk);
    chk("st_ready", {61'b0, i_ready, d_ready, mem_en}, 64'b010);
    chk("st_rdata", d_rdata, 64'd0);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_be = '0;
    tick();
    d_addr = 32'h104; d_req = 1'b1; d_exp_q.push_back(ref_mem[65]);
    serve(10);

    // Both ports saturated: 4 data grants then one fetch, repeating.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    ready_log.delete();
    done = 0; ni = 0; nd = 0;
    i_addr = 32'h40; i_req = 1'b1; i_exp_q.push_back(ref_mem[i_addr[9:2]]);
    d_addr = 32'h80; d_we = 1'b0; d_req = 1'b1; d_exp_q.push_back(ref_mem[d_addr[9:2]]);
    for (int c = 0; c < 80 && (i_req || d_req); c++) begin
      @(negedge clk);
      si = i_ready;
      sd = d_ready;
      tick();
      if (si || sd) done++;
      if (si) begin
        if (done < 10) begin
          ni++;
          i_addr = 32'h40 + 32'(ni * 4);
          i_exp_q.push_back(ref_mem[i_addr[9:2]]);
        end else i_req = 1'b0;
      end
      if (sd) begin
        if (done < 10) begin
          nd++;
          d_addr = 32'h80 + 32'(nd * 4);
          d_exp_q.push_back(ref_mem[d_addr[9:2]]);
        end else d_req = 1'b0;
      end
    end
    chk("burst_done", {62'b0, i_req, d_req}, 64'd0);
    i_req = 1'b0; d_req = 1'b0;
    chk("burst_len", ready_log.size(), 64'd11);
    for (int k = 0; k < 11; k++)
      if (k < ready_log.size())
        chk($sformatf("burst_order%0d", k), {63'b0, ready_log[k]}, {63'b0, (k % 5) == 4});

    // Reset during D_WAIT discards the load; the next load is served normally.
    tick();
    d_addr = 32'h108; d_we = 1'b0; d_req = 1'b1;
    @(negedge clk);
    chk("rd_issue", {62'b0, mem_en, mem_we}, 64'b10);
    tick();
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("rd_rst_quiet", {61'b0, i_ready, d_ready, mem_en}, 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rd_post_quiet", {61'b0, i_ready, d_ready, mem_en}, 64'd0);
    tick();
    d_addr = 32'h10C; d_req = 1'b1; d_exp_q.push_back(ref_mem[67]);
    @(negedge clk);
    chk("rd_new_issue", {62'b0, mem_en, mem_we}, 64'b10);
    chk("rd_new_addr", mem_addr, 64'h10C);
    serve(10);

    repeat (3) tick();
    chk("i_q_empty", i_exp_q.size(), 64'd0);
    chk("d_q_empty", d_exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
